// File: rtl/mem_stage_vlat.sv
// Variable-latency MEM pipeline stage between EX and WB. It waits for the data
// response, buffers it across WB stalls, extracts load data, and discards
// responses owed to flushed instructions.
module mem_stage_vlat #(
  parameter int DATA_W = 32,
  parameter int OFS_W  = $clog2(DATA_W / 8),
  parameter int DISC_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              mem_allowin,
  input  logic [31:0]       ex_pc,
  input  logic              ex_req,
  input  logic              ex_is_load,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [OFS_W-1:0]  ex_ofs,
  input  logic              ex_rf_we,
  input  logic [4:0]        ex_rf_waddr,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              data_rvalid,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              wb_allowin,
  output logic              mem_to_wb_valid,
  output logic [31:0]       wb_pc,
  output logic              wb_rf_we,
  output logic [4:0]        wb_rf_waddr,
  output logic [DATA_W-1:0] wb_rf_wdata,
  output logic              fwd_we,
  output logic [4:0]        fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata,
  output logic              fwd_stall
);

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;

  logic              valid_q,      valid_d;
  logic              wait_resp_q,  wait_resp_d;
  logic              buf_valid_q,  buf_valid_d;
  logic [DISC_W-1:0] disc_cnt_q,   disc_cnt_d;
  logic [31:0]       pc_q,         pc_d;
  logic              is_load_q,    is_load_d;
  size_e             size_q,       size_d;
  logic              unsigned_q,   unsigned_d;
  logic [OFS_W-1:0]  ofs_q,        ofs_d;
  logic              rf_we_q,      rf_we_d;
  logic [4:0]        rf_waddr_q,   rf_waddr_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [DATA_W-1:0] buf_data_q,   buf_data_d;

  logic              disc_zero, owned_beat, ready_go, leave, accept;
  logic              disc_inc, disc_dec;
  logic [DATA_W-1:0] src_data, load_data;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  logic [31:0]       sel_w;

  // Handshake and response ownership. A beat belongs to the held instruction
  // only once every response owed to flushed instructions has drained.
  always_comb begin
    disc_zero       = (disc_cnt_q == '0);
    owned_beat      = data_rvalid & disc_zero & valid_q & wait_resp_q & ~buf_valid_q;
    ready_go        = ~wait_resp_q | buf_valid_q | (data_rvalid & disc_zero);
    mem_to_wb_valid = valid_q & ready_go;
    leave           = mem_to_wb_valid & wb_allowin;
    mem_allowin     = ~valid_q | (ready_go & wb_allowin);
    accept          = ex_valid & mem_allowin & ~flush;
    disc_inc        = flush & valid_q & wait_resp_q & ~buf_valid_q & ~owned_beat;
    disc_dec        = data_rvalid & ~disc_zero;
  end

  // NOTE: every next-state signal takes its current value first, so paths that
  // do not assign it hold state instead of inferring a latch.
  always_comb begin
    valid_d      = valid_q;
    wait_resp_d  = wait_resp_q;
    buf_valid_d  = buf_valid_q;
    disc_cnt_d   = disc_cnt_q + DISC_W'(disc_inc) - DISC_W'(disc_dec);
    pc_d         = pc_q;
    is_load_d    = is_load_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    ofs_d        = ofs_q;
    rf_we_d      = rf_we_q;
    rf_waddr_d   = rf_waddr_q;
    alu_result_d = alu_result_q;
    buf_data_d   = buf_data_q;

    if (flush) begin
      valid_d     = 1'b0;
      wait_resp_d = 1'b0;
      buf_valid_d = 1'b0;
    end else begin
      if (leave) begin
        valid_d     = 1'b0;
        wait_resp_d = 1'b0;
        buf_valid_d = 1'b0;
      end else if (owned_beat) begin
        buf_valid_d = 1'b1;
        wait_resp_d = 1'b0;
        buf_data_d  = data_rdata;
      end
      if (accept) begin
        valid_d      = 1'b1;
        wait_resp_d  = ex_req;
        buf_valid_d  = 1'b0;
        pc_d         = ex_pc;
        is_load_d    = ex_is_load;
        size_d       = size_e'(ex_size);
        unsigned_d   = ex_unsigned;
        ofs_d        = ex_ofs;
        rf_we_d      = ex_rf_we;
        rf_waddr_d   = ex_rf_waddr;
        alu_result_d = ex_alu_result;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values; payload registers are cleared too so outputs read 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q      <= 1'b0;
      wait_resp_q  <= 1'b0;
      buf_valid_q  <= 1'b0;
      disc_cnt_q   <= '0;
      pc_q         <= '0;
      is_load_q    <= 1'b0;
      size_q       <= SZ_B;
      unsigned_q   <= 1'b0;
      ofs_q        <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      alu_result_q <= '0;
      buf_data_q   <= '0;
    end else begin
      valid_q      <= valid_d;
      wait_resp_q  <= wait_resp_d;
      buf_valid_q  <= buf_valid_d;
      disc_cnt_q   <= disc_cnt_d;
      pc_q         <= pc_d;
      is_load_q    <= is_load_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      ofs_q        <= ofs_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      alu_result_q <= alu_result_d;
      buf_data_q   <= buf_data_d;
    end
  end

  assign src_data = buf_valid_q ? buf_data_q : data_rdata;
  assign sel_b    = src_data[{ofs_q, 3'b000} +: 8];
  assign sel_h    = src_data[{ofs_q[OFS_W-1:1], 4'b0000} +: 16];

  // On a 32-bit bus the word is the whole bus; wider buses pick it by offset.
  if (DATA_W > 32) begin : g_word_sel
    assign sel_w = src_data[{ofs_q[OFS_W-1:2], 5'b00000} +: 32];
  end else begin : g_word_whole
    assign sel_w = src_data[31:0];
  end

  always_comb begin
    load_data = src_data;
    unique case (size_q)
      SZ_B: load_data = unsigned_q ? DATA_W'(sel_b) : DATA_W'($signed(sel_b));
      SZ_H: load_data = unsigned_q ? DATA_W'(sel_h) : DATA_W'($signed(sel_h));
      SZ_W: load_data = unsigned_q ? DATA_W'(sel_w) : DATA_W'($signed(sel_w));
      SZ_D: load_data = src_data;
    endcase
  end

  assign wb_pc       = pc_q;
  assign wb_rf_we    = mem_to_wb_valid & rf_we_q;
  assign wb_rf_waddr = rf_waddr_q;
  assign wb_rf_wdata = is_load_q ? load_data : alu_result_q;
  assign fwd_we      = valid_q & rf_we_q;
  assign fwd_waddr   = rf_waddr_q;
  assign fwd_wdata   = wb_rf_wdata;
  assign fwd_stall   = valid_q & is_load_q & ~ready_go;

endmodule
